// File: rtl/rally_referee_pkg.sv
// Shared state codes and field geometry for the rally referee and ball module.
// Common to both builds; START_DEBOUNCE_EN only affects btn_edge.
package rally_referee_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAME  = 2'd2,
    ST_END   = 2'd3
  } state_e;

  localparam int BALL_W   = 30;
  localparam int BALL_H   = 30;
  localparam int GROUND_Y = 220;
  localparam int NET_X    = 160;
  localparam int NET_W    = 6;

endpackage

// File: rtl/rally_referee_btn_edge.sv
// Button synchronizer with rising-edge strobe, reusable for any button.
// Define START_DEBOUNCE_EN to add a stable-level debounce stage.
module btn_edge
  #(parameter int DEBOUNCE_CYCLES = 1_000_000)
  (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic evt
  );

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef START_DEBOUNCE_EN
  logic [31:0] cnt;

  // Level only moves after the new value holds a full window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (s2 == lvl) begin
      cnt <= '0;
    end else if (cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      lvl <= s2;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end
`else
  logic unused_deb;
  assign unused_deb = (DEBOUNCE_CYCLES > 0);
  assign lvl = s2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lvl_q <= 1'b0;
    else          lvl_q <= lvl;
  end

  assign evt = lvl & ~lvl_q;

endmodule

// File: rtl/rally_referee.sv
// Rally referee: floor detection, scoring, serve delay and match end.
// START_DEBOUNCE_EN enables debouncing of start_btn.
module rally_referee
  import rally_referee_pkg::*;
  #(
    parameter int SERVE_DELAY     = 50_000_000,
    parameter int WIN_SCORE       = 15,
    parameter int DEBOUNCE_CYCLES = 1_000_000
  )
  (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_btn,
    input  logic [11:0] Ball_X,
    input  logic [11:0] Ball_Y,
    output logic [1:0]  Game_state,
    output logic        who_win,
    output logic [3:0]  player_score,
    output logic [3:0]  npc_score,
    output logic        point_pulse
  );

  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);
  localparam logic [31:0] LAST = 32'(SERVE_DELAY - 1);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic        armed_q;
  logic        armed_d;
  logic        who_q;
  logic        who_d;
  logic [3:0]  ps_q;
  logic [3:0]  ps_d;
  logic [3:0]  ns_q;
  logic [3:0]  ns_d;
  logic        pulse_q;
  logic        pulse_d;

  logic        start_evt;
  logic        grounded;
  logic        left_side;
  logic [12:0] bot;
  logic [12:0] ctr;
  logic [3:0]  ps_inc;
  logic [3:0]  ns_inc;

  btn_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (start_btn),
    .evt    (start_evt)
  );

  assign bot       = {1'b0, Ball_Y} + 13'(BALL_H);
  assign ctr       = {1'b0, Ball_X} + 13'(BALL_W / 2);
  assign grounded  = (bot >= 13'(GROUND_Y));
  assign left_side = (ctr < 13'(NET_X + NET_W / 2));
  assign ps_inc    = ps_q + 4'd1;
  assign ns_inc    = ns_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_START;
      timer_q <= '0;
      armed_q <= 1'b0;
      who_q   <= 1'b0;
      ps_q    <= '0;
      ns_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      who_q   <= who_d;
      ps_q    <= ps_d;
      ns_q    <= ns_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    armed_d = armed_q;
    who_d   = who_q;
    ps_d    = ps_q;
    ns_d    = ns_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_START: begin
        ps_d = '0;
        ns_d = '0;
        if (start_evt) begin
          state_d = ST_WAIT;
          timer_d = '0;
          who_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (timer_q == LAST) begin
          state_d = ST_GAME;
          timer_d = '0;
          armed_d = 1'b0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_GAME: begin
        // Floor seen before the ball ever left it is the stale reload.
        if (!armed_q) begin
          if (!grounded) armed_d = 1'b1;
        end else if (grounded) begin
          pulse_d = 1'b1;
          timer_d = '0;
          if (left_side) begin
            who_d   = 1'b0;
            ps_d    = ps_inc;
            state_d = (ps_inc == WIN4) ? ST_END : ST_WAIT;
          end else begin
            who_d   = 1'b1;
            ns_d    = ns_inc;
            state_d = (ns_inc == WIN4) ? ST_END : ST_WAIT;
          end
        end
      end
      ST_END: begin
        if (start_evt) begin
          state_d = ST_START;
          ps_d    = '0;
          ns_d    = '0;
        end
      end
    endcase
  end

  assign Game_state   = state_q;
  assign who_win      = who_q;
  assign player_score = ps_q;
  assign npc_score    = ns_q;
  assign point_pulse  = pulse_q;

endmodule

// File: tb/tb_rally_referee.sv
// Self-checking bench for rally_referee with a rule-level scoring model.
// Build with +define+START_DEBOUNCE_EN to exercise the debounce path.
module tb_rally_referee;

  localparam int SD = 4;
  localparam int WS = 3;
  localparam int DC = 8;
`ifdef START_DEBOUNCE_EN
  localparam int LAT  = 3 + DC;
  localparam int PLEN = 12;
`else
  localparam int LAT  = 3;
  localparam int PLEN = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] Ball_X = '0;
  logic [11:0] Ball_Y = '0;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ply = 0;
  int m_npc = 0;
  logic m_who = 1'b0;

  rally_referee #(
    .SERVE_DELAY(SD),
    .WIN_SCORE(WS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_btn(start_btn),
    .Ball_X(Ball_X),
    .Ball_Y(Ball_Y),
    .Game_state(Game_state),
    .who_win(who_win),
    .player_score(player_score),
    .npc_score(npc_score),
    .point_pulse(point_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    tick(2 * DC + 4);
    start_btn = 1'b1;
    tick(PLEN);
    start_btn = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget,
                            output bit ok);
    ok = (Game_state == s);
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = (Game_state == s);
    end
  endtask

  task automatic rally(input logic [11:0] x, output bit ok);
    wait_state(2'd2, 4 * SD + 20, ok);
    Ball_X = 12'($urandom_range(0, 4095));
    Ball_Y = 12'($urandom_range(0, 189));
    tick($urandom_range(1, 4));
    Ball_X = x;
    Ball_Y = 12'($urandom_range(190, 4095));
    tick(1);
  endtask

  // Ball center strictly left of net center means the NPC side missed nothing:
  // the ball landed on the left, so the player wins the rally.
  function automatic bit npc_wins(input logic [11:0] x);
    return (int'(x) + 30 / 2) >= (160 + 6 / 2);
  endfunction

  task automatic model_point(input logic [11:0] x,
                             output logic [1:0] es, output logic ew);
    if (npc_wins(x)) begin
      m_npc++;
      ew = 1'b1;
      es = (m_npc == WS) ? 2'd3 : 2'd1;
    end else begin
      m_ply++;
      ew = 1'b0;
      es = (m_ply == WS) ? 2'd3 : 2'd1;
    end
    m_who = ew;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_cmp++;
    if (Game_state !== 2'd0 || who_win !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d who=%0d want 0/0",
               Game_state, who_win);
    end
    n_cmp++;
    if (player_score !== 4'd0 || npc_score !== 4'd0 ||
        point_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_score: ply=%0d npc=%0d pulse=%0d want 0",
               player_score, npc_score, point_pulse);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_start();
    Ball_X = 12'd200;
    Ball_Y = 12'd100;
    start_btn = 1'b1;
    for (int i = 1; i <= LAT + SD; i++) begin
      tick(1);
      if (i == PLEN) start_btn = 1'b0;
      if (i == LAT - 1) begin
        n_cmp++;
        if (Game_state !== 2'd0) begin
          n_bad++;
          $display("FAIL start_early: state=%0d want 0", Game_state);
        end
      end
      if (i == LAT) begin
        n_cmp++;
        if (Game_state !== 2'd1) begin
          n_bad++;
          $display("FAIL start_lat: state=%0d want 1", Game_state);
        end
      end
      if (i == LAT + SD - 1) begin
        n_cmp++;
        if (Game_state !== 2'd1) begin
          n_bad++;
          $display("FAIL wait_len: state=%0d want 1", Game_state);
        end
      end
      if (i == LAT + SD) begin
        n_cmp++;
        if (Game_state !== 2'd2 || player_score !== 4'd0 ||
            npc_score !== 4'd0) begin
          n_bad++;
          $display("FAIL wait_end: state=%0d ply=%0d npc=%0d want 2/0/0",
                   Game_state, player_score, npc_score);
        end
      end
    end
  endtask

  task automatic test_npc_point();
    logic [1:0] es;
    logic ew;
    Ball_X = 12'd180;
    Ball_Y = 12'd100;
    tick(1);
    Ball_Y = 12'd190;
    tick(1);
    model_point(12'd180, es, ew);
    n_cmp++;
    if (point_pulse !== 1'b1 || npc_score !== 4'(m_npc) ||
        player_score !== 4'(m_ply) || who_win !== ew ||
        Game_state !== es) begin
      n_bad++;
      $display("FAIL npc_point: p=%0d n=%0d pl=%0d w=%0d s=%0d want 1/%0d/%0d/%0d/%0d",
               point_pulse, npc_score, player_score, who_win, Game_state,
               m_npc, m_ply, ew, es);
    end
    tick(1);
    n_cmp++;
    if (point_pulse !== 1'b0 || Game_state !== 2'd1) begin
      n_bad++;
      $display("FAIL pulse_width: pulse=%0d state=%0d want 0/1",
               point_pulse, Game_state);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (Game_state !== 2'd0 || who_win !== 1'b0 ||
        player_score !== 4'd0 || npc_score !== 4'd0 ||
        point_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: s=%0d w=%0d pl=%0d n=%0d p=%0d want 0",
               Game_state, who_win, player_score, npc_score, point_pulse);
    end
    m_ply = 0;
    m_npc = 0;
    m_who = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_armed_mask();
    bit ok;
    logic [1:0] es;
    logic ew;
    Ball_X = 12'd40;
    Ball_Y = 12'd190;
    press();
    wait_state(2'd2, LAT + SD + 20, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL armed_enter: timeout state=%0d want 2", Game_state);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_cmp++;
      if (point_pulse !== 1'b0 || Game_state !== 2'd2 ||
          player_score !== 4'(m_ply) || npc_score !== 4'(m_npc)) begin
        n_bad++;
        $display("FAIL armed_mask: p=%0d s=%0d pl=%0d n=%0d want 0/2/%0d/%0d",
                 point_pulse, Game_state, player_score, npc_score,
                 m_ply, m_npc);
      end
    end
    Ball_Y = 12'd50;
    tick(1);
    Ball_Y = 12'd190;
    tick(1);
    model_point(12'd40, es, ew);
    n_cmp++;
    if (point_pulse !== 1'b1 || player_score !== 4'(m_ply) ||
        npc_score !== 4'(m_npc) || who_win !== ew ||
        Game_state !== es) begin
      n_bad++;
      $display("FAIL player_point: p=%0d pl=%0d n=%0d w=%0d s=%0d want 1/%0d/%0d/%0d/%0d",
               point_pulse, player_score, npc_score, who_win, Game_state,
               m_ply, m_npc, ew, es);
    end
  endtask

  task automatic test_random_rallies();
    bit ok;
    bit done;
    logic [11:0] x;
    logic [1:0] es;
    logic ew;
    done = 1'b0;
    for (int r = 0; r < 2 * WS && !done; r++) begin
      if (r == 0)      x = 12'd147;
      else if (r == 1) x = 12'd148;
      else if (r == 2) x = 12'd4095;
      else             x = 12'($urandom_range(100, 220));
      rally(x, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rally_wait: timeout state=%0d want 2", Game_state);
      end
      model_point(x, es, ew);
      n_cmp++;
      if (point_pulse !== 1'b1 || player_score !== 4'(m_ply) ||
          npc_score !== 4'(m_npc) || who_win !== ew ||
          Game_state !== es) begin
        n_bad++;
        $display("FAIL rally x=%0d: p=%0d pl=%0d n=%0d w=%0d s=%0d want 1/%0d/%0d/%0d/%0d",
                 x, point_pulse, player_score, npc_score, who_win,
                 Game_state, m_ply, m_npc, ew, es);
      end
      if (es == 2'd3) done = 1'b1;
    end
  endtask

  task automatic test_end_freeze();
    bit ok;
    for (int i = 0; i < 8; i++) begin
      Ball_X = 12'($urandom_range(0, 4095));
      Ball_Y = 12'($urandom_range(0, 4095));
      tick(1);
      n_cmp++;
      if (Game_state !== 2'd3 || point_pulse !== 1'b0 ||
          player_score !== 4'(m_ply) || npc_score !== 4'(m_npc) ||
          who_win !== m_who) begin
        n_bad++;
        $display("FAIL end_freeze: s=%0d p=%0d pl=%0d n=%0d w=%0d want 3/0/%0d/%0d/%0d",
                 Game_state, point_pulse, player_score, npc_score, who_win,
                 m_ply, m_npc, m_who);
      end
    end
    press();
    wait_state(2'd0, LAT + 20, ok);
    m_ply = 0;
    m_npc = 0;
    n_cmp++;
    if (!ok || player_score !== 4'd0 || npc_score !== 4'd0) begin
      n_bad++;
      $display("FAIL restart: s=%0d pl=%0d n=%0d want 0/0/0",
               Game_state, player_score, npc_score);
    end
  endtask

  task automatic test_three_npc();
    bit ok;
    logic [11:0] x;
    logic [1:0] es;
    logic ew;
    Ball_Y = 12'd100;
    press();
    for (int k = 1; k <= WS; k++) begin
      x = 12'($urandom_range(148, 4095));
      rally(x, ok);
      model_point(x, es, ew);
      n_cmp++;
      if (!ok || point_pulse !== 1'b1 || npc_score !== 4'(m_npc) ||
          player_score !== 4'(m_ply) || Game_state !== es ||
          who_win !== 1'b1) begin
        n_bad++;
        $display("FAIL npc_run k=%0d: p=%0d n=%0d pl=%0d s=%0d w=%0d want 1/%0d/%0d/%0d/1",
                 k, point_pulse, npc_score, player_score, Game_state,
                 who_win, m_npc, m_ply, es);
      end
    end
    press();
    wait_state(2'd0, LAT + 20, ok);
    m_ply = 0;
    m_npc = 0;
    n_cmp++;
    if (!ok || npc_score !== 4'd0) begin
      n_bad++;
      $display("FAIL end_restart: s=%0d n=%0d want 0/0",
               Game_state, npc_score);
    end
  endtask

`ifdef START_DEBOUNCE_EN
  task automatic test_debounce();
    bit ok;
    tick(3 * DC);
    start_btn = 1'b1;
    tick(5);
    start_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_cmp++;
      if (Game_state !== 2'd0) begin
        n_bad++;
        $display("FAIL glitch: state=%0d want 0", Game_state);
      end
    end
    press();
    wait_state(2'd1, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL debounce_press: state=%0d want 1", Game_state);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_npc_point();
    test_async_reset();
    test_armed_mask();
    test_random_rallies();
    test_end_freeze();
    test_three_npc();
`ifdef START_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
